// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Signal bundle between a byte-stream source, the boot loader
//                and the instruction-memory write port / CPU hold control.
//                  rx_data    [7:0]        received byte
//                  rx_valid                one-cycle byte strobe
//                  imem_we                 one-cycle word write strobe
//                  imem_addr  [ADDR_W-1:0] word write address
//                  imem_wdata [31:0]       word write data
//                  cpu_hold                1 = keep CPU in reset
//                  load_done              last frame loaded, checksum good
//                  load_err               last frame aborted
//                master : byte source side (drives rx_*, observes the rest)
//                slave  : loader side (consumes rx_*, drives the rest)
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Framed byte-stream boot loader. Frame = A5, N (16b LE),
//                4*N data bytes (words LSB first), XOR checksum of data.
//                Words go to consecutive imem addresses from 0; the CPU is
//                held in reset until a frame completes with a good checksum.
//  Ports       : sys_clk  - clock, rising edge
//                sys_rst  - synchronous active-high reset
//                bus      - imem_loader_if.slave (rx byte in, imem write
//                           port and status out)
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  wire logic    sys_clk,
    input  wire logic    sys_rst,
    imem_loader_if.slave bus
);

    localparam int               c_cnt_w        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      c_depth        = 17'(2 ** ADDR_W);
    localparam logic [7:0]       c_sync         = 8'hA5;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_len0 = 3'd1;
    localparam logic [2:0] c_st_len1 = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_csum = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;
    localparam logic [2:0] c_st_err  = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [15:0]        r_len;
    logic [16:0]        r_word_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_word;
    logic [7:0]         r_csum;
    logic [c_cnt_w-1:0] r_idle_cnt;

    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic               r_cpu_hold;
    logic               r_load_done;
    logic               r_load_err;

    logic               w_active;
    logic               w_sync;
    logic               w_timeout;
    logic               w_last_byte;
    logic               w_last_word;
    logic [15:0]        w_len_full;

    assign w_active    = (r_state == c_st_len0) || (r_state == c_st_len1) ||
                         (r_state == c_st_data) || (r_state == c_st_csum);
    assign w_sync      = bus.rx_valid && (bus.rx_data == c_sync);
    // A byte arriving on the expiry cycle still counts, so timeout needs silence.
    assign w_timeout   = w_active && !bus.rx_valid && (r_idle_cnt == c_timeout_last);
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = ((r_word_cnt + 17'd1) == {1'b0, r_len});
    assign w_len_full  = {bus.rx_data, r_len[7:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle, c_st_done, c_st_err: begin
                if (w_sync) begin
                    w_next_state = c_st_len0;
                end
            end
            c_st_len0: begin
                if (bus.rx_valid) begin
                    w_next_state = c_st_len1;
                end
            end
            c_st_len1: begin
                if (bus.rx_valid) begin
                    if ({1'b0, w_len_full} > c_depth) begin
                        w_next_state = c_st_err;
                    end else if (w_len_full == 16'd0) begin
                        w_next_state = c_st_csum;
                    end else begin
                        w_next_state = c_st_data;
                    end
                end
            end
            c_st_data: begin
                if (bus.rx_valid && w_last_byte && w_last_word) begin
                    w_next_state = c_st_csum;
                end
            end
            c_st_csum: begin
                if (bus.rx_valid) begin
                    w_next_state = (bus.rx_data == r_csum) ? c_st_done : c_st_err;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
        if (w_timeout) begin
            w_next_state = c_st_err;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_addr       <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_idle_cnt   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;

            if (w_active && !bus.rx_valid && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end

            case (r_state)
                c_st_idle, c_st_done, c_st_err: begin
                    if (w_sync) begin
                        r_load_done <= 1'b0;
                        r_load_err  <= 1'b0;
                        r_cpu_hold  <= 1'b1;
                        r_addr      <= '0;
                        r_word_cnt  <= '0;
                        r_byte_idx  <= '0;
                        r_word      <= '0;
                        r_csum      <= '0;
                    end
                end
                c_st_len0: begin
                    if (bus.rx_valid) begin
                        r_len[7:0] <= bus.rx_data;
                    end
                end
                c_st_len1: begin
                    if (bus.rx_valid) begin
                        r_len[15:8] <= bus.rx_data;
                        if (w_next_state == c_st_err) begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                c_st_data: begin
                    if (bus.rx_valid) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        r_csum     <= r_csum ^ bus.rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            // Write port takes the completed word directly so the
                            // shift register is free for the next word's lane 0.
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_addr;
                            r_imem_wdata <= {bus.rx_data, r_word[23:0]};
                            r_addr       <= r_addr + 1'b1;
                            r_word_cnt   <= r_word_cnt + 17'd1;
                        end
                    end
                end
                c_st_csum: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == r_csum) begin
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_timeout) begin
                r_load_err <= 1'b1;
                r_word     <= '0;
                r_byte_idx <= '0;
            end
        end
    end

    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader
//                (ADDR_W=10, TIMEOUT_CYC=50). Writes are logged on the
//                falling edge and compared against hand-derived values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(
        .ADDR_W      (10),
        .TIMEOUT_CYC (50)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    // Drive one byte for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got %b want 1", bus.cpu_hold); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus.imem_wdata); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.load_done); end
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.load_err); end
    endtask

    task automatic test_normal();
        logic [7:0] fr [12];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h91};
        clear_log();
        for (int i = 0; i < 11; i++) send(fr[i]);
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL norm_pre_done got %b want 0", bus.load_done); end
        send(fr[11]);
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL norm_done got %b want 1", bus.load_done); end
        checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL norm_hold got %b want 0", bus.cpu_hold); end
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL norm_err got %b want 0", bus.load_err); end
        idle(2);
        checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL norm_wcount got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            checks++; if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h00000093) begin errors++; $display("FAIL norm_w0 got %h=%h want 000=00000093", wr_addr_q[0], wr_data_q[0]); end
            checks++; if (wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'h00100113) begin errors++; $display("FAIL norm_w1 got %h=%h want 001=00100113", wr_addr_q[1], wr_data_q[1]); end
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] fr [12];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h90};
        clear_log();
        send(fr[0]);
        checks++; if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL bad_sync hold=%b done=%b want 1 0", bus.cpu_hold, bus.load_done); end
        for (int i = 1; i < 12; i++) send(fr[i]);
        checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", bus.load_err); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL bad_hold got %b want 1", bus.cpu_hold); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL bad_done got %b want 0", bus.load_done); end
        idle(1);
        checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL bad_wcount got %0d want 2", wr_addr_q.size()); end
        fr[11] = 8'h91;
        for (int i = 0; i < 12; i++) send(fr[i]);
        checks++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL bad_retry done=%b err=%b hold=%b want 1 0 0", bus.load_done, bus.load_err, bus.cpu_hold); end
    endtask

    task automatic test_oversize();
        clear_log();
        send(8'hA5); send(8'h01); send(8'h04);
        checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL over_err got %b want 1", bus.load_err); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL over_hold got %b want 1", bus.cpu_hold); end
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h00);
        idle(1);
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL over_wcount got %0d want 0", wr_addr_q.size()); end
        checks++; if (bus.load_err !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL over_trail err=%b done=%b want 1 0", bus.load_err, bus.load_done); end
    endtask

    task automatic test_timeout();
        clear_log();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL to_start got %b want 0", bus.load_err); end
        idle(49);
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", bus.load_err); end
        idle(1);
        checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", bus.load_err); end
        checks++; if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL to_status hold=%b done=%b want 1 0", bus.cpu_hold, bus.load_done); end
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL to_wcount got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_noise_empty();
        clear_log();
        send(8'h00); send(8'hFF); send(8'h5A);
        checks++; if (bus.load_err !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL noise_ign err=%b done=%b want 1 0", bus.load_err, bus.load_done); end
        send(8'hA5);
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL noise_clr got %b want 0", bus.load_err); end
        send(8'h00); send(8'h00); send(8'h00);
        checks++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL empty_done done=%b hold=%b want 1 0", bus.load_done, bus.cpu_hold); end
        idle(1);
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL empty_wcount got %0d want 0", wr_addr_q.size()); end
    endtask

    // N = 1024 is the largest legal count; word i = {4{i[7:0]}} so the XOR is 0.
    task automatic test_full_depth();
        int bad;
        logic [7:0] b;
        clear_log();
        send(8'hA5); send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            b = 8'(i);
            repeat (4) send(b);
        end
        send(8'h00);
        checks++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0) begin errors++; $display("FAIL full_done done=%b err=%b want 1 0", bus.load_done, bus.load_err); end
        idle(1);
        checks++; if (wr_addr_q.size() !== 1024) begin errors++; $display("FAIL full_wcount got %0d want 1024", wr_addr_q.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            b = 8'(i);
            if (wr_addr_q[i] !== 10'(i) || wr_data_q[i] !== {4{b}}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_seq got %0d bad words want 0", bad); end
        checks++; if (bus.imem_addr !== 10'h3FF || bus.imem_wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL full_last got %h=%h want 3ff=ffffffff", bus.imem_addr, bus.imem_wdata); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin errors++; $display("FAIL rmid_status hold=%b done=%b err=%b want 1 0 0", bus.cpu_hold, bus.load_done, bus.load_err); end
        checks++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL rmid_bus we=%b addr=%h data=%h want 0 0 0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        send(8'hCC); send(8'hDD);
        idle(1);
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL rmid_ign got %0d writes want 0", wr_addr_q.size()); end
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b want 1", bus.load_done); end
        idle(1);
        checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL rmid_wcount got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1) begin
            checks++; if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h44332211) begin errors++; $display("FAIL rmid_w0 got %h=%h want 000=44332211", wr_addr_q[0], wr_data_q[0]); end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_normal();
        test_bad_csum();
        test_oversize();
        test_timeout();
        test_noise_empty();
        test_full_depth();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
